// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: predicted-PC register, length/status decode and the F/D pipeline register.
// Optional macro FETCH_PREDICT_TAKEN_EN predicts conditional jumps taken (default: not-taken).
module fetch_stage #(
    parameter int unsigned         DATA_WID  = 64,
    parameter int unsigned         MEM_BYTES = 2048,
    parameter logic [DATA_WID-1:0] RESET_PC  = {DATA_WID{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    output logic [DATA_WID-1:0] PC,
    input  logic [3:0]          icode,
    input  logic [3:0]          ifun,
    input  logic [3:0]          rA,
    input  logic [3:0]          rB,
    input  logic [DATA_WID-1:0] valC,
    input  logic                redirect_valid,
    input  logic [DATA_WID-1:0] redirect_pc,
    input  logic                F_stall,
    input  logic                D_stall,
    input  logic                D_bubble,
    output logic [3:0]          D_icode,
    output logic [3:0]          D_ifun,
    output logic [3:0]          D_rA,
    output logic [3:0]          D_rB,
    output logic [DATA_WID-1:0] D_valC,
    output logic [DATA_WID-1:0] D_valP,
    output logic [2:0]          D_stat,
    output logic                halted
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [DATA_WID:0] MEM_LIMIT = (DATA_WID+1)'(MEM_BYTES);

    function automatic logic fields_valid(input logic [3:0] ic, input logic [3:0] fn);
        case (ic)
            I_RRMOVQ, I_JXX: fields_valid = (fn <= 4'd6);
            I_OPQ:           fields_valid = (fn <= 4'd3);
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ:
                             fields_valid = (fn == 4'd0);
            default:         fields_valid = 1'b0;
        endcase
    endfunction

    logic [DATA_WID-1:0] pred_pc_r;
    logic                halted_r;
    logic [DATA_WID-1:0] pc_s;
    logic                need_regids_s;
    logic                need_valc_s;
    logic [3:0]          len_s;
    logic [DATA_WID-1:0] len_ext_s;
    logic [DATA_WID-1:0] valp_s;
    logic [DATA_WID:0]   end_addr_s;
    logic [2:0]          stat_s;
    logic [DATA_WID-1:0] next_pc_s;
    logic                hold_fetch_s;
    logic                load_s;

    assign pc_s         = redirect_valid ? redirect_pc : pred_pc_r;
    assign PC           = pc_s;
    assign halted       = halted_r;
    assign hold_fetch_s = halted_r && !redirect_valid;
    assign load_s       = !rst && !D_stall && !D_bubble && !hold_fetch_s;

    // Decode which optional instruction fields are present.
    always_comb begin
        need_regids_s = 1'b0;
        need_valc_s   = 1'b0;
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids_s = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids_s = 1'b1;
                need_valc_s   = 1'b1;
            end
            I_JXX, I_CALL: need_valc_s = 1'b1;
            default: begin
                need_regids_s = 1'b0;
                need_valc_s   = 1'b0;
            end
        endcase
    end

    assign len_s      = 4'd1 + {3'b000, need_regids_s} + (need_valc_s ? 4'd8 : 4'd0);
    assign len_ext_s  = {{(DATA_WID-4){1'b0}}, len_s};
    assign valp_s     = pc_s + len_ext_s;
    // One extra bit so an instruction straddling the top of the address space still faults.
    assign end_addr_s = {1'b0, pc_s} + {1'b0, len_ext_s};

    // Fetch status, address fault taking priority over decode faults.
    always_comb begin
        stat_s = STAT_AOK;
        if (end_addr_s > MEM_LIMIT) begin
            stat_s = STAT_ADR;
        end else if (!fields_valid(icode, ifun)) begin
            stat_s = STAT_INS;
        end else if (icode == I_HALT) begin
            stat_s = STAT_HLT;
        end else begin
            stat_s = STAT_AOK;
        end
    end

    // Next-PC prediction.
    always_comb begin
        next_pc_s = valp_s;
        case (icode)
            I_CALL: next_pc_s = valC;
            I_JXX: begin
                if (ifun == 4'd0) begin
                    next_pc_s = valC;
                end else begin
`ifdef FETCH_PREDICT_TAKEN_EN
                    next_pc_s = valC;
`else
                    next_pc_s = valp_s;
`endif
                end
            end
            default: next_pc_s = valp_s;
        endcase
    end

    // Predicted-PC register; a faulting fetch parks on its own address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_pc_r <= RESET_PC;
        end else if (F_stall || hold_fetch_s) begin
            pred_pc_r <= pred_pc_r;
        end else if (stat_s != STAT_AOK) begin
            pred_pc_r <= pc_s;
        end else begin
            pred_pc_r <= next_pc_s;
        end
    end

    // F/D pipeline register.
    always_ff @(posedge clk) begin
        if (rst || (!D_stall && (D_bubble || hold_fetch_s))) begin
            D_icode <= I_NOP;
            D_ifun  <= 4'd0;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= {DATA_WID{1'b0}};
            D_valP  <= {DATA_WID{1'b0}};
            D_stat  <= STAT_AOK;
        end else if (D_stall) begin
            D_icode <= D_icode;
            D_ifun  <= D_ifun;
            D_rA    <= D_rA;
            D_rB    <= D_rB;
            D_valC  <= D_valC;
            D_valP  <= D_valP;
            D_stat  <= D_stat;
        end else begin
            D_icode <= icode;
            D_ifun  <= ifun;
            D_rA    <= need_regids_s ? rA : REG_NONE;
            D_rB    <= need_regids_s ? rB : REG_NONE;
            D_valC  <= valC;
            D_valP  <= valp_s;
            D_stat  <= stat_s;
        end
    end

    // Sticky halt; a redirect means the faulting instruction was on a squashed path.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if (load_s && (stat_s != STAT_AOK)) begin
            halted_r <= 1'b1;
        end else if (redirect_valid) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= halted_r;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed test-plan sequence followed by randomized traffic.
module tb_fetch_stage;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        logic        halted;
    } dstate_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] PC;
    logic [3:0]  icode = 4'h1, ifun = 4'h0, rA = 4'hF, rB = 4'hF;
    logic [63:0] valC = 64'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [2:0]  D_stat;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [63:0] pc_q[$];
    dstate_t     st_q[$];

    logic [63:0] m_pred = 64'd0;
    logic        m_init = 1'b0;
    dstate_t     m_d;

    fetch_stage dut (
        .clk(clk), .rst(rst), .PC(PC),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat), .halted(halted)
    );

    initial forever #5 clk = ~clk;

    function automatic dstate_t bubble_state(input logic h);
        dstate_t b;
        b.icode = 4'h1; b.ifun = 4'h0; b.ra = 4'hF; b.rb = 4'hF;
        b.valc = 64'd0; b.valp = 64'd0; b.stat = 3'd1; b.halted = h;
        return b;
    endfunction

    function automatic bit legal(input logic [3:0] ic, input logic [3:0] fn);
        int max_fn;
        if (ic > 4'hB) return 1'b0;
        max_fn = (ic == 4'h2 || ic == 4'h7) ? 6 : (ic == 4'h6) ? 3 : 0;
        return int'(fn) <= max_fn;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and queue what the DUT must show.
    task automatic drive(input logic r, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] a, input logic [3:0] b, input logic [63:0] vc,
                         input logic rvv, input logic [63:0] rp,
                         input logic fs, input logic ds, input logic db);
        logic [63:0] pc, vp, np;
        int          len;
        logic [2:0]  st;
        bit          hold, load, regs;
        dstate_t     nd;
        @(negedge clk);
        rst = r; icode = ic; ifun = fn; rA = a; rB = b; valC = vc;
        redirect_valid = rvv; redirect_pc = rp;
        F_stall = fs; D_stall = ds; D_bubble = db;
        #1;
        pc = rvv ? rp : m_pred;
        if (m_init || rvv) pc_q.push_back(pc);
        regs = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        len  = 1 + (regs ? 1 : 0) + ((ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) ? 8 : 0);
        vp   = pc + 64'(len);
        if (pc > 64'(2048 - len))  st = 3'd3;
        else if (!legal(ic, fn))   st = 3'd4;
        else if (ic == 4'h0)       st = 3'd2;
        else                       st = 3'd1;
        if (ic == 4'h8 || (ic == 4'h7 && fn == 4'h0)) np = vc;
`ifdef FETCH_PREDICT_TAKEN_EN
        else if (ic == 4'h7) np = vc;
`endif
        else np = vp;
        if (r) begin
            m_pred = 64'd0;
            nd = bubble_state(1'b0);
            m_init = 1'b1;
        end else begin
            hold = m_d.halted && !rvv;
            if (!fs && !hold) m_pred = (st != 3'd1) ? pc : np;
            load = !ds && !db && !hold;
            if (ds) nd = m_d;
            else if (db || hold) nd = bubble_state(m_d.halted);
            else begin
                nd.icode = ic; nd.ifun = fn;
                nd.ra = regs ? a : 4'hF; nd.rb = regs ? b : 4'hF;
                nd.valc = vc; nd.valp = vp; nd.stat = st; nd.halted = m_d.halted;
            end
            if (load && st != 3'd1) nd.halted = 1'b1;
            else if (rvv)           nd.halted = 1'b0;
            else                    nd.halted = m_d.halted;
        end
        m_d = nd;
        st_q.push_back(nd);
    endtask

    task automatic nop_cyc();
        drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic redir(input logic [63:0] rp);
        drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b1, rp, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: PC mid-low-phase, F/D state just after each rising edge.
    initial begin
        logic [63:0] epc;
        dstate_t     e;
        forever begin
            @(negedge clk); #2;
            if (pc_q.size() > 0) begin
                epc = pc_q.pop_front();
                chk("pc", PC, epc);
            end
            @(posedge clk); #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                checks++;
                if (D_icode !== e.icode || D_ifun !== e.ifun || D_rA !== e.ra || D_rB !== e.rb ||
                    D_valC !== e.valc || D_valP !== e.valp || D_stat !== e.stat || halted !== e.halted) begin
                    errors++;
                    $display("FAIL fd_state: got ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h stat=%0d halted=%b, want ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h stat=%0d halted=%b",
                             D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat, halted,
                             e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat, e.halted);
                end
            end
        end
    end

    initial begin
        logic [3:0]  ic, fn;
        logic [63:0] vc, rp;
        logic        r, rvv, fs, ds, db;
        // Reset
        drive(1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_pc", PC, 64'd0);
        chk("reset_icode", {60'd0, D_icode}, 64'd1);
        chk("reset_regs", {56'd0, D_rA, D_rB}, 64'hFF);
        // Sequential fetch and jumps
        drive(1'b0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h55, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("irmovq_pc", PC, 64'h0);
        chk("reset_stat", {61'd0, D_stat}, 64'd1);
        chk("reset_halted", {63'd0, halted}, 64'd0);
        nop_cyc();
        chk("nop_pc", PC, 64'hA);
        chk("irmovq_valp", D_valP, 64'hA);
        drive(1'b0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h10, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("after_nop_pc", PC, 64'hB);
        drive(1'b0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("jmp_at_10", PC, 64'h10);
        drive(1'b0, 4'h7, 4'h4, 4'hF, 4'hF, 64'h80, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("jmp_target", PC, 64'h40);
        // Stall and bubble
        drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
`ifdef FETCH_PREDICT_TAKEN_EN
        chk("jne_target", PC, 64'h80);
`else
        chk("jne_target", PC, 64'h49);
`endif
        chk("jne_loaded", {60'd0, D_icode}, 64'd7);
        drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        chk("stall_hold", {60'd0, D_icode}, 64'd7);
        drive(1'b0, 4'h3, 4'h0, 4'h1, 4'h2, 64'h99, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("bubble_icode", {60'd0, D_icode}, 64'd1);
        drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        nop_cyc();
        chk("stall_beats_bubble", {60'd0, D_icode}, 64'd3);
        // Halt and redirect
        redir(64'h1F);
        drive(1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("halt_pc", PC, 64'h20);
        nop_cyc();
        chk("halt_stat", {61'd0, D_stat}, 64'd2);
        chk("halt_set", {63'd0, halted}, 64'd1);
        chk("halt_park", PC, 64'h20);
        nop_cyc();
        chk("halt_bubble", {60'd0, D_icode}, 64'd1);
        redir(64'h30);
        chk("redirect_pc", PC, 64'h30);
        nop_cyc();
        chk("halt_cleared", {63'd0, halted}, 64'd0);
        chk("resume_pc", PC, 64'h31);
        // Faults
        redir(64'h7F7);
        drive(1'b0, 4'h3, 4'h0, 4'hF, 4'h1, 64'd7, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("adr_pc", PC, 64'h7F8);
        nop_cyc();
        chk("adr_stat", {61'd0, D_stat}, 64'd3);
        drive(1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        nop_cyc();
        chk("ins_stat", {61'd0, D_stat}, 64'd4);
        chk("ins_park", PC, 64'h0);
        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 63) == 0);
            rvv = ($urandom_range(0, 7) == 0);
            fs  = ($urandom_range(0, 5) == 0);
            ds  = ($urandom_range(0, 5) == 0);
            db  = ($urandom_range(0, 5) == 0);
            rp  = 64'($urandom_range(0, 2040));
            if (rvv) begin
                drive(r, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1'b1, rp, 1'b0, ds, db);
            end else begin
                ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
                if ($urandom_range(0, 3) == 0)        fn = 4'($urandom_range(0, 15));
                else if (ic == 4'h2 || ic == 4'h7)    fn = 4'($urandom_range(0, 6));
                else if (ic == 4'h6)                  fn = 4'($urandom_range(0, 3));
                else                                  fn = 4'h0;
                vc = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 2047));
                drive(r, ic, fn, 4'($urandom), 4'($urandom), vc, 1'b0, 64'd0, fs, ds, db);
            end
        end
        nop_cyc();
        @(posedge clk); #3;
        chk("scoreboard_drained", 64'(pc_q.size() + st_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch-stage control for the pipelined Y86-64 core. The block owns the predicted-PC register and drives `PC` into the instruction memory. It takes the memory's decoded fields (`icode`, `ifun`, `rA`, `rB`, `valC`), computes instruction length, `valP` and the next predicted PC, and classifies fetch status. Results are latched into the F/D pipeline register consumed by decode, under stall/bubble control from the hazard unit.

## Interface
- `DATA_WID`, 64: address/data width.
- `MEM_BYTES`, 2048: instruction memory size in bytes.
- `RESET_PC`, 0: PC after reset.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `PC` out DATA_WID: fetch address to instruction memory; combinational.
- `icode`, `ifun`, `rA`, `rB` in 4 each: fields from instruction memory.
- `valC` in DATA_WID: constant word from instruction memory, already aligned for JXX/CALL.
- `redirect_valid` in 1: a later stage (mispredict or RET) overrides fetch this cycle.
- `redirect_pc` in DATA_WID: override address.
- `F_stall` in 1: hold the predicted-PC register.
- `D_stall` in 1: hold the F/D register.
- `D_bubble` in 1: load a bubble into F/D.
- `D_icode`, `D_ifun`, `D_rA`, `D_rB` out 4 each: registered fields.
- `D_valC`, `D_valP` out DATA_WID: registered constant and sequential PC.
- `D_stat` out 3: registered status. 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- `halted` out 1: sticky; set once a non-AOK instruction enters F/D.

## Operation
- `PC = redirect_valid ? redirect_pc : predPC`.
- Field validity:
  - ifun must be 0, except icode 2 (ifun ≤ 6), icode 6 (ifun ≤ 3) and icode 7 (ifun ≤ 6).
  - icode > 0xB is invalid.
- `need_regids` = icode ∈ {2,3,4,5,6,A,B}.
- `need_valC` = icode ∈ {3,4,5,7,8}.
- Length arithmetic:
  - `len = 1 + need_regids + 8·need_valC`.
  - `valP = PC + len`, truncated to DATA_WID; wraps silently.
- When `need_regids` = 0, the F/D register gets `rA` = `rB` = 0xF.
- Status priority: ADR (`PC + len > MEM_BYTES`, compared at DATA_WID+1 bits) > INS (invalid icode/ifun) > HLT (icode 0) > AOK.
- Predicted next PC:
  - `valC` for CALL and for JXX with ifun 0.
  - `valC` or `valP` for conditional JXX (see Configuration).
  - `valP` for everything else.
- predPC update, first match wins:
  1. `rst` → RESET_PC.
  2. `F_stall` → hold.
  3. `halted` && !`redirect_valid` → hold.
  4. Status ≠ AOK → `PC`; fetch parks on the faulting instruction.
  5. Otherwise → predicted next PC.
- F/D update, first match wins:
  1. `rst` → bubble.
  2. `D_stall` → hold.
  3. `D_bubble` → bubble.
  4. `halted` && !`redirect_valid` → bubble.
  5. Otherwise → load the current fields, `valP` and status.
- Bubble contents: icode 1, ifun 0, rA = rB = 0xF, valC = valP = 0, stat AOK.
- `halted` update:
  - Sets on a load of non-AOK status.
  - Clears on `rst`.
  - Clears on any cycle with `redirect_valid`; the halting instruction was on a squashed path and fetch resumes at `redirect_pc`.
- `D_stall` && `D_bubble` both high: stall wins.
- `F_stall` with `redirect_valid`: predPC holds; the redirect is lost. The hazard unit must not assert both.

## Timing
- `PC`, status and `valP` are combinational from predPC, the redirect inputs and the memory fields within the same cycle.
- predPC, the F/D outputs and `halted` update on the rising edge.
- F/D latency: one cycle from `PC` presentation.
- Reset values:
  - `PC` = RESET_PC, unless `redirect_valid` is high.
  - F/D = bubble.
  - `halted` = 0.
- Reset mid-stall or mid-halt: all state returns to reset values in the next cycle.

## Configuration
- `FETCH_PREDICT_TAKEN_EN`:
  - Defined: conditional JXX (ifun 1–6) predicted taken, next PC = `valC`.
  - Undefined: predicted not-taken, next PC = `valP`.
- CALL and unconditional JMP go to `valC` in both builds.

## Test plan
- Reset:
  - `rst` high 2 cycles → `PC` = 0, `D_icode` = 1, `D_rA` = `D_rB` = 0xF, `D_stat` = 1, `halted` = 0.
- Sequential fetch:
  - irmovq (icode 3) at 0x0, then nop at 0xA, both AOK → `PC` sequence 0x0, 0xA, 0xB.
  - `D_valP` = 0xA after the first edge.
- Jumps:
  - jmp at 0x10, valC 0x40 → next `PC` = 0x40.
  - jne at 0x40, valC 0x80 → next `PC` = 0x80 with the macro defined, 0x49 without.
- Stall/bubble:
  - `F_stall` = `D_stall` = 1 for 2 cycles → `PC` and all D outputs unchanged.
  - Then `D_bubble` = 1 → D becomes a bubble.
  - `D_stall` && `D_bubble` together → D holds.
- Halt and redirect:
  - halt at 0x20 → `D_stat` = 2, `halted` = 1, `PC` stays 0x20, the next D is a bubble.
  - `redirect_valid` with `redirect_pc` = 0x30 → `PC` = 0x30 that cycle, `halted` = 0 next cycle.
- Faults:
  - irmovq at 0x7F8 (0x7F8 + 10 > 2048) → `D_stat` = 3.
  - icode 0xC at 0x0 → `D_stat` = 4, PC parks at 0x0.
